// File: rtl/add_accumulator_pkg.sv
// Shared types and helpers for the add_accumulator stage.
// Holds the FSM state encoding and the saturation constant helpers.
package add_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int unsigned MAX_W = 64;

   function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/add_accumulator_adder.sv
// Ripple-carry adder block feeding the add_accumulator stage.
// Carry is chained through a loop variable so no combinational vector loops.
module fullAdderBlock #(
   parameter int DATA_SIZE_PARAMETER = 8
) (
   input  logic [DATA_SIZE_PARAMETER-1:0] dataA,
   input  logic [DATA_SIZE_PARAMETER-1:0] dataB,
   input  logic                           cin,
   output logic [DATA_SIZE_PARAMETER-1:0] sum_out,
   output logic                           carry
);

   always_comb begin
      logic c;
      c = cin;
      sum_out = '0;
      for (int i = 0; i < DATA_SIZE_PARAMETER; i++) begin
         sum_out[i] = dataA[i] ^ dataB[i] ^ c;
         c = (dataA[i] & dataB[i]) | (c & (dataA[i] ^ dataB[i]));
      end
      carry = c;
   end

endmodule

// File: rtl/add_accumulator.sv
// Multi-beat add/sub accumulator around fullAdderBlock with result handshake.
// Define ACC_SATURATE_EN to clamp the accumulator on signed overflow.
module add_accumulator
   import add_accumulator_pkg::*;
#(
   parameter int DATA_SIZE_PARAMETER = 8,
   parameter int CNT_WIDTH           = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_SIZE_PARAMETER-1:0] in_data,
   input  logic                           in_sub,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_SIZE_PARAMETER-1:0] out_sum,
   output logic                           out_carry,
   output logic                           out_overflow,
   output logic [CNT_WIDTH-1:0]           out_count
);

   localparam int MSB = DATA_SIZE_PARAMETER - 1;

   state_t                         state;
   logic [DATA_SIZE_PARAMETER-1:0] acc;
   logic [DATA_SIZE_PARAMETER-1:0] data_b;
   logic [DATA_SIZE_PARAMETER-1:0] sum_out;
   logic [DATA_SIZE_PARAMETER-1:0] acc_next;
   logic                           carry;
   logic                           carry_q;
   logic                           ovf_q;
   logic                           ovf_beat;
   logic                           valid_q;
   logic [CNT_WIDTH-1:0]           cnt;
   logic [CNT_WIDTH-1:0]           cnt_next;
   logic                           beat;
   logic                           done;

   // Subtract as A + ~B + 1; carry-out of 1 then means no borrow.
   assign data_b = in_sub ? ~in_data : in_data;

   fullAdderBlock #(
      .DATA_SIZE_PARAMETER(DATA_SIZE_PARAMETER)
   ) u_adder (
      .dataA  (acc),
      .dataB  (data_b),
      .cin    (in_sub),
      .sum_out(sum_out),
      .carry  (carry)
   );

   assign ovf_beat = (acc[MSB] == data_b[MSB]) &&
                     (sum_out[MSB] != acc[MSB]);

`ifdef ACC_SATURATE_EN
   localparam logic [DATA_SIZE_PARAMETER-1:0] SAT_MAX =
      DATA_SIZE_PARAMETER'(sat_max(DATA_SIZE_PARAMETER));
   localparam logic [DATA_SIZE_PARAMETER-1:0] SAT_MIN =
      DATA_SIZE_PARAMETER'(sat_min(DATA_SIZE_PARAMETER));

   always_comb begin
      acc_next = sum_out;
      if (ovf_beat)
         acc_next = acc[MSB] ? SAT_MIN : SAT_MAX;
   end
`else
   assign acc_next = sum_out;
`endif

   assign cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);

   assign in_ready = (state != HOLD);
   assign beat     = in_valid & in_ready;
   assign done     = valid_q & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt     <= '0;
         valid_q <= 1'b0;
      end else if (clear) begin
         state   <= IDLE;
         acc     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt     <= '0;
         valid_q <= 1'b0;
      end else begin
         unique case (1'b1)
            beat: begin
               acc     <= acc_next;
               carry_q <= carry;
               ovf_q   <= ovf_q | ovf_beat;
               cnt     <= cnt_next;
               if (in_last) begin
                  state   <= HOLD;
                  valid_q <= 1'b1;
               end else begin
                  state   <= RUN;
               end
            end
            done: begin
               state   <= IDLE;
               acc     <= '0;
               carry_q <= 1'b0;
               ovf_q   <= 1'b0;
               cnt     <= '0;
               valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid    = valid_q;
   assign out_sum      = acc;
   assign out_carry    = carry_q;
   assign out_overflow = ovf_q;
   assign out_count    = cnt;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed self-checking bench for add_accumulator (8-bit data).
// Expected values are hand computed; ACC_SATURATE_EN selects clamp results.
module tb_add_accumulator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       in_sub = 1'b0;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_sum;
   logic       out_carry;
   logic       out_overflow;
   logic [3:0] out_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   add_accumulator #(
      .DATA_SIZE_PARAMETER(8),
      .CNT_WIDTH          (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sub      (in_sub),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_carry   (out_carry),
      .out_overflow(out_overflow),
      .out_count   (out_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic sub,
                       input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_sub   = sub;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_sub   = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic v,
                          input logic [7:0] s, input logic c,
                          input logic o, input logic [3:0] n);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_sum"}, 32'(out_sum), 32'(s));
      chk({tag, "_carry"}, 32'(out_carry), 32'(c));
      chk({tag, "_ovf"}, 32'(out_overflow), 32'(o));
      chk({tag, "_count"}, 32'(out_count), 32'(n));
   endtask

   initial begin
      logic [7:0] exp_pos;
      logic [7:0] exp_neg;
`ifdef ACC_SATURATE_EN
      exp_pos = 8'h7F;
      exp_neg = 8'h80;
`else
      exp_pos = 8'h96;
      exp_neg = 8'h6A;
`endif
      #12;
      chk_out("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
      rst_n = 1'b1;
      step();
      chk("rst_ready", 32'(in_ready), 32'd1);

      // reset mid-run after two beats, checked before any clock edge
      send(8'd5, 1'b0, 1'b0);
      send(8'd10, 1'b0, 1'b0);
      chk("pre_rst_sum", 32'(out_sum), 32'h0F);
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
      #1;
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", 32'(in_ready), 32'd1);

      // add run
      send(8'd5, 1'b0, 1'b0);
      send(8'd10, 1'b0, 1'b0);
      send(8'd20, 1'b0, 1'b1);
      chk_out("add", 1'b1, 8'h23, 1'b0, 1'b0, 4'd3);
      chk("add_ready", 32'(in_ready), 32'd0);
      handshake();
      chk_out("add_done", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);

      // subtract
      send(8'd10, 1'b0, 1'b0);
      send(8'd3, 1'b1, 1'b1);
      chk_out("sub", 1'b1, 8'h07, 1'b1, 1'b0, 4'd2);
      handshake();
      send(8'd1, 1'b1, 1'b1);
      chk_out("sub1", 1'b1, 8'hFF, 1'b0, 1'b0, 4'd1);
      handshake();

      // signed overflow both directions
      send(8'd100, 1'b0, 1'b0);
      send(8'd50, 1'b0, 1'b1);
      chk_out("ovf_pos", 1'b1, exp_pos, 1'b0, 1'b1, 4'd2);
      handshake();
      send(8'h9C, 1'b0, 1'b0);
      chk("ovf_neg_mid", 32'(out_overflow), 32'd0);
      send(8'hCE, 1'b0, 1'b1);
      chk_out("ovf_neg", 1'b1, exp_neg, 1'b1, 1'b1, 4'd2);
      handshake();

      // backpressure while beats are offered
      send(8'd1, 1'b0, 1'b0);
      send(8'd2, 1'b0, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h40;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out("bp", 1'b1, 8'h03, 1'b0, 1'b0, 4'd2);
         chk("bp_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      handshake();
      chk_out("bp_done", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
      chk("bp_done_ready", 32'(in_ready), 32'd1);

      // idle in RUN holds state
      send(8'd6, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk_out("run_hold", 1'b0, 8'h06, 1'b0, 1'b0, 4'd1);

      // clear collides with a last beat
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd9;
      in_last  = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk_out("clr_beat", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
      send(8'd4, 1'b0, 1'b1);
      chk_out("clr_after", 1'b1, 8'h04, 1'b0, 1'b0, 4'd1);

      // clear collides with out handshake
      clear     = 1'b1;
      out_ready = 1'b1;
      step();
      clear     = 1'b0;
      out_ready = 1'b0;
      chk_out("clr_hold", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
      chk("clr_hold_ready", 32'(in_ready), 32'd1);

      // beat counter saturates at 15
      for (int i = 0; i < 15; i++) send(8'd1, 1'b0, 1'b0);
      chk("cnt_15", 32'(out_count), 32'd15);
      send(8'd1, 1'b0, 1'b1);
      chk_out("cnt_sat", 1'b1, 8'h10, 1'b0, 1'b0, 4'd15);
      handshake();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_accumulator.md
Name: add_accumulator

Overview:
- Multi-beat accumulator stage built around the ripple-carry adder block `fullAdderBlock`.
- Accepts a stream of operands over a valid/ready handshake and adds or subtracts each operand into a running register. The register's output feeds back as adder operand A.
- On the last beat, presents the result with carry and sticky overflow flags over an output valid/ready handshake.
- Sits directly downstream of `fullAdderBlock`: it consumes `sum_out` and `carry` and drives `dataA`, `dataB` and `cin`.

Parameters:
- DATA_SIZE_PARAMETER, default 8: operand, accumulator and result width in bits.
- CNT_WIDTH, default 4: width of the beat counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous abort; discards the run and returns to IDLE.
- in_valid, input, 1: operand beat is valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, DATA_SIZE_PARAMETER: operand.
- in_sub, input, 1: 1 means subtract in_data; 0 means add.
- in_last, input, 1: this beat ends the run.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- out_sum, output, DATA_SIZE_PARAMETER: accumulated result.
- out_carry, output, 1: adder carry-out of the final beat.
- out_overflow, output, 1: sticky signed overflow for the run.
- out_count, output, CNT_WIDTH: number of beats accepted in the run.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE; accumulator, flags and counter are 0.
  - out_valid=0, out_sum=0, out_carry=0, out_overflow=0, out_count=0.
  - in_ready=1 once rst_n is released.
  - Reset asserted mid-run or in HOLD discards everything immediately.
- Beat acceptance: a beat is accepted when in_valid & in_ready are both high at a rising edge.
- Adder hookup:
  - dataA = acc.
  - dataB = in_sub ? ~in_data : in_data.
  - cin = in_sub.
  - On acceptance: acc <= sum_out; carry register <= carry (1 on subtract means no borrow).
- Signed overflow for a beat: sign(dataA) == sign(dataB) and sign(sum_out) != sign(dataA). The overflow flag is ORed (sticky) across the run.
- Beat counter: increments on each accepted beat and saturates at all-ones (no wrap).
- States:
  - IDLE: in_ready=1, acc=0. An accepted beat moves to RUN, or to HOLD if in_last=1.
  - RUN: in_ready=1. An accepted beat with in_last=1 moves to HOLD.
  - HOLD:
    - in_ready=0, out_valid=1.
    - out_sum, out_carry, out_overflow and out_count are stable while out_ready=0.
    - out_valid & out_ready moves to IDLE and clears acc, flags and counter.
    - No beat is accepted in the handshake cycle (no bypass).
- Latency: out_valid rises on the cycle after the in_last beat is accepted. A single-beat run is legal.
- Output signals: out_* are registered and reflect the accumulator at all times; only out_valid qualifies them.
- clear:
  - Highest priority after reset, in every state.
  - A beat presented in the same cycle is dropped, a pending result is discarded, and the block goes to IDLE.
  - clear together with out_ready in HOLD discards the result; it does not count as a handshake.
- in_valid=0 in RUN: state is held indefinitely.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on a beat with signed overflow, acc loads 0111…1 if sign(dataA)=0, else 1000…0. out_overflow is still set and out_carry still takes the raw adder carry.
- Undefined: acc wraps modulo 2^DATA_SIZE_PARAMETER.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - saturation constants SAT_MAX and SAT_MIN, derived from DATA_SIZE_PARAMETER.
- One sub-module: instance of the existing `fullAdderBlock` with DATA_SIZE_PARAMETER passed through. The FSM, operand conditioning and registers live in add_accumulator.

Test Plan (DATA_SIZE_PARAMETER=8):
1. Reset: pulse rst_n low mid-run after 2 beats -> all out_* = 0 asynchronously; IDLE; in_ready=1 after release.
2. Add run: beats +5, +10, +20 (last) -> next cycle out_valid=1, out_sum=0x23, out_carry=0, out_overflow=0, out_count=3.
3. Subtract: +10, then sub 3 (last) -> out_sum=0x07, out_carry=1. Single beat sub 1 from IDLE -> out_sum=0xFF, out_carry=0.
4. Overflow: +100, +50 (last) -> out_overflow=1. out_sum=0x96 without ACC_SATURATE_EN; 0x7F with it. Then -100, -50 -> 0x6A, or 0x80 with ACC_SATURATE_EN.
5. Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> outputs stable, in_ready=0, no beat absorbed. Then out_ready=1 -> IDLE next cycle, out_valid=0.
6. clear collision: clear=1 with in_valid=1, in_last=1 -> beat dropped, IDLE, out_valid stays 0. clear=1 with out_ready=1 in HOLD -> result discarded, out_count=0.
